if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//   Parametrised instruction-fetch front end: PC generator, fixed-latency IMEM request port and a
//   DEPTH-entry {PC,INSTR} queue feeding decode over a valid/ready handshake. Sits between the
//   instruction memory and the ID stage. Replaces the single-entry IF/ID register, adding fetch
//   decoupling, back-pressure and branch redirect with squash of queued and in-flight fetches.
// PARAMETERS
//   XLEN      32            PC / address width
//   DEPTH     4             queue entries; power of 2, >= 2
//   RESET_PC  32'h0000_0000 PC loaded on reset
//   PC_STEP   4             PC increment per sequential fetch
// PORTS
//   clk             in   1        clock; all state changes on rising edge
//   reset           in   1        synchronous, active-low reset
//   PCSrc           in   1        redirect (taken branch/jump) from EX
//   PC_Branch       in   XLEN     redirect target, valid when PCSrc=1
//   imem_req        out  1        fetch request this cycle
//   imem_addr       out  XLEN     fetch address (= pc_q)
//   imem_rdata      in   32       instruction, valid exactly 1 cycle after imem_req
//   ID_ready        in   1        decode accepts head this cycle (IF_ID_write)
//   ID_valid        out  1        head entry valid
//   PC_ID           out  XLEN     PC of head entry
//   INSTRUCTION_ID  out  32       head instruction; NOP 32'h0000_0013 when ID_valid=0
//   q_count         out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//   - Reset (reset=0 at edge): pc_q<=RESET_PC, rd/wr ptrs<=0, q_count<=0, inflight<=0.
//     While reset=0: imem_req=0, ID_valid=0, INSTRUCTION_ID=NOP, PC_ID=0. Reset wins over all.
//   - Credit rule: imem_req = reset & ~PCSrc & (q_count + inflight < DEPTH). Guarantees a
//     returning response always has a free slot; push-when-full cannot occur.
//   - On request: pc_q<=pc_q+PC_STEP (mod 2^XLEN), inflight<=1, pc_inflight<=pc_q.
//   - Response: cycle after request, {pc_inflight, imem_rdata} pushed at wr_ptr unless squashed.
//     Fetch-to-ID_valid latency = 2 cycles from imem_req when queue empty.
//   - Pop: ID_valid & ID_ready & ~PCSrc -> rd_ptr advances. Head outputs are combinational
//     from the entry at rd_ptr.
//   - Simultaneous push+pop: both take effect, q_count unchanged.
//   - Pointers are log2(DEPTH) bits and wrap naturally; q_count in 0..DEPTH.
//   - Redirect (PCSrc=1): pc_q<=PC_Branch; ptrs and q_count cleared; no pop, no request;
//     inflight response of the same cycle is dropped, any request issued the prior cycle is
//     marked squash and its response discarded next cycle. ID_valid=0 the cycle after.
//     First request at PC_Branch issues the cycle after PCSrc (redirect penalty >= 3 cycles).
//   - Back-to-back PCSrc: last target wins; each cycle re-clears queue.
//   - ID_ready while ID_valid=0: no effect.
// CONFIGURATION
//   IFQ_PERF_EN defined: adds outputs stall_cycles[31:0] (cycles with ID_valid=1 & ID_ready=0)
//     and flush_count[31:0] (cycles with PCSrc=1); both saturate at all-ones, reset to 0.
//   IFQ_PERF_EN undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//   riscv_pkg: NOP_INSTR (32'h0000_0013), XLEN default, ifq_entry_t {pc, instr} typedef.
//   Sub-module ifq_fifo: DEPTH x (XLEN+32) storage, ptrs, count, sync clear; fetch/credit/
//   squash logic stays in if_fetch_queue.
// TESTING
//   1 Reset: hold reset=0 3 cycles -> imem_req=0, ID_valid=0, INSTRUCTION_ID=32'h13; release ->
//     imem_addr=0x0, then 0x4, 0x8 on consecutive cycles with ID_ready=1.
//   2 Back-pressure, DEPTH=4: ID_ready=0 -> exactly 4 requests (0x0..0xC), q_count=4, imem_req=0;
//     ID_ready=1 one cycle -> one pop of PC 0x0, next request at 0x10.
//   3 Redirect: queue holds 0x4..0xC, request at 0x10 in flight, PCSrc=1 PC_Branch=0x100 ->
//     next cycle q_count=0, ID_valid=0, 0x10 data discarded; next request imem_addr=0x100.
//   4 Push+pop same cycle at q_count=2 -> q_count stays 2, order preserved (PC 0x0,0x4,0x8...).
//   5 Wrap: RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000;
//     ptr wrap after 2*DEPTH pops with no loss or reordering.
//   6 IFQ_PERF_EN: 5 cycles ID_valid=1/ID_ready=0 then 2 PCSrc pulses -> stall_cycles=5,
//     flush_count=2.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-path types: NOP encoding, default address width and the queue entry layout.
package riscv_pkg;
  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             instr;
  } ifq_entry_t;
endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry circular buffer of {pc, instr} words with occupancy count and a synchronous clear.
module ifq_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(ifq_entry_t),
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push = push_i & ~clr_i;
    do_pop  = pop_i & ~clr_i & (cnt_q != '0);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_o.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: PC generator, 1-cycle IMEM port and decoupling queue toward ID.
// Optional IFQ_PERF_EN adds saturating stall/flush counters.
module if_fetch_queue
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4,
  localparam int             CW       = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PC_Branch,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            ID_ready,
  output logic            ID_valid,
  output logic [XLEN-1:0] PC_ID,
  output logic [31:0]     INSTRUCTION_ID,
  output logic [CW-1:0]   q_count
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_count
`endif
);
  logic [XLEN-1:0]    pc_q, pc_d, pc_infl_q, pc_infl_d;
  logic               infl_q, infl_d;
  logic               credit_ok, push, pop;
  logic [XLEN+31:0]   head;
  logic [CW-1:0]      fifo_cnt;

  // Counting the in-flight fetch as occupied means a response always finds a free slot.
  assign credit_ok = (int'(fifo_cnt) + int'(infl_q)) < DEPTH;
  assign imem_req  = reset & ~PCSrc & credit_ok;
  assign imem_addr = pc_q;
  assign push      = reset & infl_q & ~PCSrc;
  assign pop       = ID_valid & ID_ready & ~PCSrc;

  always_comb begin
    pc_d      = pc_q;
    infl_d    = imem_req;
    pc_infl_d = pc_infl_q;
    if (PCSrc) begin
      pc_d = PC_Branch;
    end else if (imem_req) begin
      pc_d      = pc_q + XLEN'(PC_STEP);
      pc_infl_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      pc_infl_q <= '0;
    end else begin
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      pc_infl_q <= pc_infl_d;
    end
  end

  ifq_fifo #(.DEPTH(DEPTH), .W(XLEN + 32)) u_fifo (
    .clk     (clk),
    .rst_n_i (reset),
    .clr_i   (PCSrc),
    .push_i  (push),
    .wdata_i ({pc_infl_q, imem_rdata}),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_cnt)
  );

  assign ID_valid       = reset & (fifo_cnt != '0);
  assign PC_ID          = ID_valid ? head[XLEN+31:32] : '0;
  assign INSTRUCTION_ID = ID_valid ? head[31:0] : NOP_INSTR;
  assign q_count        = fifo_cnt;

`ifdef IFQ_PERF_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (ID_valid && !ID_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (PCSrc && flush_q != '1)                 flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: reset, back-pressure, redirect, push+pop, PC wrap, perf counters.
module tb_if_fetch_queue;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        rst0, pcsrc0, rdy0, req0, vld0;
  logic [31:0] br0, rdata0, addr0, pcid0, ins0;
  logic [2:0]  cnt0;
  logic        rst1, pcsrc1, rdy1, req1, vld1;
  logic [31:0] br1, rdata1, addr1, pcid1, ins1;
  logic [2:0]  cnt1;
`ifdef IFQ_PERF_EN
  logic [31:0] stall0, flush0, stall1, flush1;
`endif

  if_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) u0 (
    .clk(clk), .reset(rst0), .PCSrc(pcsrc0), .PC_Branch(br0),
    .imem_req(req0), .imem_addr(addr0), .imem_rdata(rdata0),
    .ID_ready(rdy0), .ID_valid(vld0), .PC_ID(pcid0), .INSTRUCTION_ID(ins0),
    .q_count(cnt0)
`ifdef IFQ_PERF_EN
    , .stall_cycles(stall0), .flush_count(flush0)
`endif
  );

  if_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) u1 (
    .clk(clk), .reset(rst1), .PCSrc(pcsrc1), .PC_Branch(br1),
    .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
    .ID_ready(rdy1), .ID_valid(vld1), .PC_ID(pcid1), .INSTRUCTION_ID(ins1),
    .q_count(cnt1)
`ifdef IFQ_PERF_EN
    , .stall_cycles(stall1), .flush_count(flush1)
`endif
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // IMEM models: capture request mid-cycle, present data for the whole following cycle.
  initial begin
    logic r; logic [31:0] a;
    rdata0 = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk); r = req0; a = addr0;
      @(posedge clk); #1;
      rdata0 = r ? mem(a) : 32'hDEAD_BEEF;
    end
  end

  initial begin
    logic r; logic [31:0] a;
    rdata1 = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk); r = req1; a = addr1;
      @(posedge clk); #1;
      rdata1 = r ? mem(a) : 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic reset0();
    rst0 = 1'b0; pcsrc0 = 1'b0; br0 = '0; rdy0 = 1'b0;
    repeat (2) cyc();
    rst0 = 1'b1;
  endtask

  initial begin
    rst0 = 1'b0; pcsrc0 = 1'b0; br0 = '0; rdy0 = 1'b1;
    rst1 = 1'b0; pcsrc1 = 1'b0; br1 = '0; rdy1 = 1'b1;

    // Reset hold, then sequential fetch
    repeat (3) cyc();
    #1;
    chk("rst_req", req0, 0);
    chk("rst_vld", vld0, 0);
    chk("rst_ins", ins0, 32'h13);
    chk("rst_pc", pcid0, 0);
    chk("rst_cnt", cnt0, 0);
    cyc(); rst0 = 1'b1; #1;
    chk("seq_req0", req0, 1);
    chk("seq_addr0", addr0, 32'h0);
    cyc(); #1;
    chk("seq_addr1", addr1 === 32'hx ? addr0 : addr0, 32'h4);
    cyc(); #1;
    chk("seq_addr2", addr0, 32'h8);
    chk("seq_vld", vld0, 1);
    chk("seq_pcid", pcid0, 32'h0);
    chk("seq_ins", ins0, mem(32'h0));

    // Back-pressure: four requests fill the queue
    reset0();
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("bp_req%0d", k), req0, (k < 4) ? 1 : 0);
      if (k < 4) chk($sformatf("bp_addr%0d", k), addr0, 32'(4 * k));
      if (k < 5) cyc();
    end
    chk("bp_cnt", cnt0, 4);
    chk("bp_head", pcid0, 32'h0);
    rdy0 = 1'b1; #1;
    chk("bp_pop_pc", pcid0, 32'h0);
    cyc(); rdy0 = 1'b0; #1;
    chk("bp_next_pc", pcid0, 32'h4);
    chk("bp_cnt3", cnt0, 3);
    chk("bp_req10", req0, 1);
    chk("bp_addr10", addr0, 32'h10);

    // Redirect with 0x4..0xC queued and 0x10 returning this cycle
    cyc(); pcsrc0 = 1'b1; br0 = 32'h100; #1;
    chk("rd_noreq", req0, 0);
    cyc(); pcsrc0 = 1'b0; #1;
    chk("rd_cnt", cnt0, 0);
    chk("rd_vld", vld0, 0);
    chk("rd_ins", ins0, 32'h13);
    chk("rd_req", req0, 1);
    chk("rd_addr", addr0, 32'h100);
    cyc(); #1;
    chk("rd_vld_lat", vld0, 0);
    cyc(); #1;
    chk("rd_vld2", vld0, 1);
    chk("rd_pc", pcid0, 32'h100);
    chk("rd_ins2", ins0, mem(32'h100));
    chk("rd_cnt1", cnt0, 1);

    // Back-to-back redirects: last target wins
    pcsrc0 = 1'b1; br0 = 32'h200;
    cyc(); br0 = 32'h300; #1;
    chk("b2b_cnt", cnt0, 0);
    chk("b2b_vld", vld0, 0);
    cyc(); pcsrc0 = 1'b0; #1;
    chk("b2b_addr", addr0, 32'h300);
    chk("b2b_req", req0, 1);

    // Simultaneous push and pop at q_count=2
    reset0();
    repeat (3) cyc();
    rdy0 = 1'b1; #1;
    chk("pp_cnt0", cnt0, 2);
    chk("pp_pc0", pcid0, 32'h0);
    for (int k = 1; k < 5; k++) begin
      cyc(); #1;
      chk($sformatf("pp_cnt%0d", k), cnt0, 2);
      chk($sformatf("pp_pc%0d", k), pcid0, 32'(4 * k));
    end

    // Address wrap and pointer wrap on u1
    cyc(); rst1 = 1'b1; #1;
    chk("wr_addr0", addr1, 32'hFFFF_FFF8);
    cyc(); #1;
    chk("wr_addr1", addr1, 32'hFFFF_FFFC);
    cyc(); #1;
    chk("wr_addr2", addr1, 32'h0000_0000);
    for (int k = 0; k < 10; k++) begin
      logic [31:0] pc;
      pc = 32'hFFFF_FFF8 + 32'(4 * k);
      if (k > 0) begin cyc(); #1; end
      chk($sformatf("wr_vld%0d", k), vld1, 1);
      chk($sformatf("wr_pc%0d", k), pcid1, pc);
      chk($sformatf("wr_ins%0d", k), ins1, mem(pc));
    end

`ifdef IFQ_PERF_EN
    // Five stall cycles, then two redirect pulses
    reset0();
    repeat (7) cyc();
    rdy0 = 1'b1; pcsrc0 = 1'b1; br0 = 32'h40;
    cyc(); pcsrc0 = 1'b0;
    cyc(); pcsrc0 = 1'b1;
    cyc(); pcsrc0 = 1'b0; #1;
    chk("perf_stall", stall0, 5);
    chk("perf_flush", flush0, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
